wdt_multi_channel: RTL and testbench
====================================

Name: wdt_multi_channel

Overview:
- N-channel successor to the single-channel broadcast watchdog.
- Each channel supervises one control source (host link, sequencer, audio DMA, etc.):
  - per-channel runtime-programmable timeout and enable;
  - sticky trip, explicit clear, minimum hold-off after clear;
  - saturating trip counter.
- A masked OR of channel trips drives the global RF kill (broadcast_enable_safe = request & ~kill). Sits between the AXI register bank and the NCO/modulator chain.

Parameters:
- N_CH, 4, number of supervised channels
- CLK_FREQ, 125_000_000, clk frequency in Hz
- TICK_HZ, 1000, timebase tick rate; timeouts are in ticks
- CNT_W, 16, tick counter and timeout width
- WARN_PCT, 80, warning threshold as integer percent of timeout (1..99)
- HOLDOFF_TICKS, 100, ticks a channel stays tripped after clear before re-arming
- TRIPCNT_W, 8, width of each saturating trip counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  N_CH  per-channel enable, level
- kick  in  N_CH  per-channel heartbeat, one-cycle pulse
- clear  in  N_CH  per-channel trip clear, one-cycle pulse
- timeout_cfg  in  N_CH*CNT_W  per-channel timeout in ticks, channel i at [i*CNT_W +: CNT_W]
- window_cfg  in  N_CH*CNT_W  per-channel early-kick window in ticks (used only with WDT_WINDOW_EN)
- trip_mask  in  N_CH  1 = channel trip contributes to kill
- triggered  out  N_CH  channel tripped or in hold-off
- warning  out  N_CH  channel at or past warning threshold, or tripped
- early_fault  out  N_CH  sticky; trip was caused by an early kick
- kill  out  1  registered |(triggered & trip_mask)
- remaining  out  N_CH*CNT_W  ticks until trip
- trip_count  out  N_CH*TRIPCNT_W  saturating count of trips

Behaviour:
- Reset (rst_n low at a clk edge):
  - all channels go to DIS; all counters are 0;
  - triggered, warning, early_fault, kill, remaining and trip_count are 0;
  - tick prescaler is 0.
- Timebase:
  - prescaler counts 0..CLK_FREQ/TICK_HZ-1;
  - tick is a one-cycle pulse on wrap;
  - tick is shared by all channels.
- Per-channel FSM states: DIS, RUN, WARN, TRIP, HOLD.
- Latching:
  - timeout_lat, window_lat and warn_thr are latched on DIS->RUN and on every accepted kick;
  - warn_thr = (timeout_cfg*WARN_PCT)/100, computed at CNT_W+7 bits, truncated;
  - config changes mid-interval have no effect until the next latch.
- DIS:
  - cnt=0, outputs low;
  - enable=1 and timeout_cfg!=0 -> RUN.
  - timeout_cfg==0 keeps the channel in DIS.
- RUN / WARN counting:
  - tick: cnt<=cnt+1.
  - kick: cnt<=0, state RUN, relatch.
  - kick and tick in the same cycle: kick wins.
- RUN -> WARN when cnt>=warn_thr (warning=1).
- Trip condition: in RUN or WARN, a tick with cnt+1>=timeout_lat -> TRIP.
  - triggered=1 and warning=1 in the next cycle.
  - trip_count increments and saturates at all-ones.
  - Trip occurs exactly timeout_lat ticks after the last accepted kick.
- TRIP:
  - sticky; kicks are ignored;
  - clear -> HOLD with cnt=0.
- HOLD:
  - triggered stays 1; kicks are ignored;
  - counts ticks; when cnt+1>=HOLDOFF_TICKS -> RUN with cnt=0;
  - triggered, warning and early_fault clear on entry to RUN.
- enable=0 in any state:
  - -> DIS next cycle;
  - triggered, warning and early_fault clear;
  - trip_count is kept.
- clear outside TRIP is ignored.
- kill is registered: it asserts 1 cycle after triggered rises and drops 1 cycle after it falls.
- remaining:
  - timeout_lat-cnt in RUN/WARN;
  - 0 in TRIP/HOLD/DIS;
  - registered, same cycle as state.
- Channels are fully independent; simultaneous trips on several channels each count.

Optional Feature:
- Macro: WDT_WINDOW_EN.
- Defined (windowed watchdog):
  - a kick in RUN/WARN with cnt<window_lat -> TRIP (early_fault=1, trip_count increments);
  - window_cfg>=timeout_cfg means every kick is early, which trips the channel; integration must prevent that configuration.
- Undefined:
  - window_cfg is ignored;
  - early_fault is tied to 0;
  - every kick in RUN/WARN is accepted.

Decomposition:
- Package wdt_pkg holds:
  - state enum (DIS, RUN, WARN, TRIP, HOLD);
  - localparams TICK_DIV = CLK_FREQ/TICK_HZ and its width ($clog2);
  - helper function for the warn_thr computation.
- Sub-module wdt_channel: one FSM, counter, latch registers and trip counter. Instantiated N_CH times in a generate loop.
- The top level holds the tick prescaler and kill reduction.

Test Plan:
Bench settings: CLK_FREQ=1000, TICK_HZ=100 (tick every 10 clk), N_CH=2, HOLDOFF_TICKS=3.
- Reset: hold rst_n=0 for 5 clk with kick and enable toggling -> all outputs 0 and prescaler 0 after release.
- Basic trip: ch0 enable=1, timeout=10, mask=1, no kicks -> warning at tick 8; triggered after tick 10; kill 1 clk later; trip_count=1; remaining=0.
- Kicking: kick ch0 every 9 ticks for 50 ticks -> triggered never asserts; a kick coincident with a tick leaves cnt=0.
- Sticky and hold-off: after a trip, kicks do nothing. A clear pulse keeps triggered=1 for exactly 3 ticks, then RUN with remaining=10. A clear during RUN is ignored.
- Masking and independence: ch1 trips with mask=0b01 -> triggered[1]=1, kill=0. Set enable[1]=0 -> triggered[1]=0, trip_count[1] kept. Saturation: 260 forced trips -> trip_count=255.
- WDT_WINDOW_EN: window=4, timeout=10; kick at cnt=2 -> TRIP with early_fault=1. Kick at cnt=6 -> accepted. Without the macro, the same stimulus -> no trip.

Source files
------------

// File: rtl/wdt_pkg.sv
// ---------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the multi-channel watchdog:
//   - per-channel FSM state encodings (DIS, RUN, WARN, TRIP, HOLD)
//   - timebase helpers (tick divider and its counter width)
//   - warning-threshold helper: (timeout * pct) / 100, truncated
// Optional feature macro used by the design: WDT_WINDOW_EN (windowed kicks).
// ---------------------------------------------------------------------------
package wdt_pkg;

  localparam logic [2:0] ST_DIS  = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_WARN = 3'd2;
  localparam logic [2:0] ST_TRIP = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  // Clock cycles per timebase tick; never below 1.
  function automatic int tick_div(input int clk_freq, input int tick_hz);
    return (clk_freq / tick_hz > 0) ? clk_freq / tick_hz : 1;
  endfunction

  // Counter width for a modulus; at least one bit so a divide-by-1 still builds.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Product is formed wide enough that the multiply cannot overflow for any
  // 32-bit timeout; callers truncate to their counter width.
  function automatic logic [39:0] warn_threshold(input logic [31:0] timeout,
                                                 input int unsigned pct);
    logic [39:0] product;
    product = {8'd0, timeout} * 40'(pct);
    return product / 40'd100;
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// ---------------------------------------------------------------------------
// wdt_channel
// One supervised channel: FSM, tick counter, latched config and a saturating
// trip counter. Outputs are decoded directly from registered state.
// Optional feature: WDT_WINDOW_EN -- kicks arriving before window_lat ticks
// trip the channel and set early_fault. Without it window_cfg is ignored and
// early_fault is 0.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   tick              shared timebase pulse
//   enable            channel enable (level)
//   kick, clear       heartbeat and trip-clear pulses
//   timeout_cfg       timeout in ticks (0 keeps the channel disabled)
//   window_cfg        early-kick window in ticks
//   triggered         tripped or in hold-off
//   warning           at/past warning threshold, or tripped
//   early_fault       trip was caused by an early kick (sticky)
//   remaining         ticks until trip while counting, else 0
//   trip_count        saturating trip count
// ---------------------------------------------------------------------------
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int WARN_PCT      = 80,
  parameter int HOLDOFF_TICKS = 100,
  parameter int TRIPCNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 enable,
  input  logic                 kick,
  input  logic                 clear,
  input  logic [CNT_W-1:0]     timeout_cfg,
  input  logic [CNT_W-1:0]     window_cfg,
  output logic                 triggered,
  output logic                 warning,
  output logic                 early_fault,
  output logic [CNT_W-1:0]     remaining,
  output logic [TRIPCNT_W-1:0] trip_count
);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] timeout_lat;
  logic [CNT_W-1:0] warn_thr;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cfg_thr;
  logic             running;
  logic             start;
  logic             early_kick;
  logic             kick_ok;
  logic             kick_bad;
  logic             tick_trip;
  logic             hold_done;
  logic             relatch;

  assign cfg_thr   = CNT_W'(warn_threshold(32'(timeout_cfg), WARN_PCT));
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
  assign running   = (state == ST_RUN) || (state == ST_WARN);
  assign start     = (state == ST_DIS) && (timeout_cfg != '0);
  assign kick_ok   = running && kick && !early_kick;
  assign kick_bad  = running && kick && early_kick;
  // A kick in the same cycle as a tick wins, so the tick cannot trip.
  assign tick_trip = running && !kick && tick && (cnt_inc >= {1'b0, timeout_lat});
  assign hold_done = (state == ST_HOLD) && tick &&
                     (cnt_inc >= (CNT_W+1)'(HOLDOFF_TICKS));
  assign relatch   = enable && (start || kick_ok);

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] window_lat;
  logic             early_r;

  assign early_kick  = (cnt < window_lat);
  assign early_fault = early_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_lat <= '0;
      early_r    <= 1'b0;
    end else begin
      if (relatch) window_lat <= window_cfg;
      if (!enable)                 early_r <= 1'b0;
      else if (kick_bad)           early_r <= 1'b1;
      else if (hold_done)          early_r <= 1'b0;
    end
  end
`else
  logic unused_window;

  assign unused_window = ^window_cfg;
  assign early_kick    = 1'b0;
  assign early_fault   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: latched config is reset along with the FSM so remaining and the
      // compare logic never see X after reset.
      state       <= ST_DIS;
      cnt         <= '0;
      timeout_lat <= '0;
      warn_thr    <= '0;
      trip_count  <= '0;
    end else begin
      if (relatch) begin
        timeout_lat <= timeout_cfg;
        warn_thr    <= cfg_thr;
      end
      if (!enable) begin
        state <= ST_DIS;
        cnt   <= '0;
      end else begin
        case (state)
          ST_DIS: begin
            if (start) begin
              cnt   <= '0;
              state <= (cfg_thr == '0) ? ST_WARN : ST_RUN;
            end
          end
          ST_RUN, ST_WARN: begin
            if (kick_bad || tick_trip) begin
              state <= ST_TRIP;
              cnt   <= '0;
              if (trip_count != '1) trip_count <= trip_count + TRIPCNT_W'(1);
            end else if (kick_ok) begin
              cnt   <= '0;
              state <= (cfg_thr == '0) ? ST_WARN : ST_RUN;
            end else if (tick) begin
              cnt   <= cnt_inc[CNT_W-1:0];
              state <= (cnt_inc >= {1'b0, warn_thr}) ? ST_WARN : ST_RUN;
            end
          end
          ST_TRIP: begin
            if (clear) begin
              state <= ST_HOLD;
              cnt   <= '0;
            end
          end
          ST_HOLD: begin
            if (hold_done) begin
              cnt   <= '0;
              state <= (warn_thr == '0) ? ST_WARN : ST_RUN;
            end else if (tick) begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end
          default: state <= ST_DIS;
        endcase
      end
    end
  end

  assign triggered = (state == ST_TRIP) || (state == ST_HOLD);
  assign warning   = triggered || (state == ST_WARN);
  assign remaining = running ? (timeout_lat - cnt) : '0;

endmodule

// File: rtl/wdt_multi_channel.sv
// ---------------------------------------------------------------------------
// wdt_multi_channel
// N-channel broadcast watchdog. Holds the shared tick prescaler and the
// registered, masked kill reduction; each channel is a wdt_channel instance.
// Optional feature: WDT_WINDOW_EN enables windowed (early-kick) supervision.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   enable         per-channel enable
//   kick, clear    per-channel heartbeat / trip-clear pulses
//   timeout_cfg    per-channel timeout, channel i at [i*CNT_W +: CNT_W]
//   window_cfg     per-channel early-kick window (WDT_WINDOW_EN only)
//   trip_mask      1 = channel trip contributes to kill
//   triggered      per-channel tripped or in hold-off
//   warning        per-channel warning
//   early_fault    per-channel early-kick trip flag
//   kill           registered |(triggered & trip_mask)
//   remaining      per-channel ticks until trip
//   trip_count     per-channel saturating trip counts
// ---------------------------------------------------------------------------
module wdt_multi_channel
  import wdt_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CLK_FREQ      = 125_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int CNT_W         = 16,
  parameter int WARN_PCT      = 80,
  parameter int HOLDOFF_TICKS = 100,
  parameter int TRIPCNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           enable,
  input  logic [N_CH-1:0]           kick,
  input  logic [N_CH-1:0]           clear,
  input  logic [N_CH*CNT_W-1:0]     timeout_cfg,
  input  logic [N_CH*CNT_W-1:0]     window_cfg,
  input  logic [N_CH-1:0]           trip_mask,
  output logic [N_CH-1:0]           triggered,
  output logic [N_CH-1:0]           warning,
  output logic [N_CH-1:0]           early_fault,
  output logic                      kill,
  output logic [N_CH*CNT_W-1:0]     remaining,
  output logic [N_CH*TRIPCNT_W-1:0] trip_count
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, TICK_HZ);
  localparam int PRESC_W  = clog2_min1(TICK_DIV);

  logic [PRESC_W-1:0] presc;
  logic               tick;

  // tick is high for the single cycle in which the prescaler wraps.
  assign tick = (presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PRESC_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wdt_channel #(
      .CNT_W         (CNT_W),
      .WARN_PCT      (WARN_PCT),
      .HOLDOFF_TICKS (HOLDOFF_TICKS),
      .TRIPCNT_W     (TRIPCNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .enable      (enable[i]),
      .kick        (kick[i]),
      .clear       (clear[i]),
      .timeout_cfg (timeout_cfg[i*CNT_W +: CNT_W]),
      .window_cfg  (window_cfg[i*CNT_W +: CNT_W]),
      .triggered   (triggered[i]),
      .warning     (warning[i]),
      .early_fault (early_fault[i]),
      .remaining   (remaining[i*CNT_W +: CNT_W]),
      .trip_count  (trip_count[i*TRIPCNT_W +: TRIPCNT_W])
    );
  end

  // Registered so the RF kill path is glitch-free; lags triggered by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) kill <= 1'b0;
    else        kill <= |(triggered & trip_mask);
  end

endmodule

// File: tb/tb_wdt_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_wdt_multi_channel
// Scenario tasks plus a randomized phase, all checked against a behavioural
// model of the watchdog rules (modes OFF / COUNTING / TRIPPED / HOLDING,
// warning derived from the count versus the latched threshold).
// ---------------------------------------------------------------------------
module tb_wdt_multi_channel;

  localparam int N_CH          = 2;
  localparam int CLK_FREQ      = 1000;
  localparam int TICK_HZ       = 100;
  localparam int CNT_W         = 16;
  localparam int WARN_PCT      = 80;
  localparam int HOLDOFF_TICKS = 3;
  localparam int TRIPCNT_W     = 8;
  localparam int DIV           = CLK_FREQ / TICK_HZ;

`ifdef WDT_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  localparam int M_OFF  = 0;
  localparam int M_CNT  = 1;
  localparam int M_TRIP = 2;
  localparam int M_HOLD = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_CH-1:0]           enable;
  logic [N_CH-1:0]           kick;
  logic [N_CH-1:0]           clear;
  logic [N_CH*CNT_W-1:0]     timeout_cfg;
  logic [N_CH*CNT_W-1:0]     window_cfg;
  logic [N_CH-1:0]           trip_mask;
  logic [N_CH-1:0]           triggered;
  logic [N_CH-1:0]           warning;
  logic [N_CH-1:0]           early_fault;
  logic                      kill;
  logic [N_CH*CNT_W-1:0]     remaining;
  logic [N_CH*TRIPCNT_W-1:0] trip_count;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  int m_mode [N_CH];
  int m_cnt  [N_CH];
  int m_tlat [N_CH];
  int m_wlat [N_CH];
  int m_thr  [N_CH];
  int m_tc   [N_CH];
  bit m_ef   [N_CH];
  bit m_kill;
  int m_presc;
  bit m_tick;

  wdt_multi_channel #(
    .N_CH          (N_CH),
    .CLK_FREQ      (CLK_FREQ),
    .TICK_HZ       (TICK_HZ),
    .CNT_W         (CNT_W),
    .WARN_PCT      (WARN_PCT),
    .HOLDOFF_TICKS (HOLDOFF_TICKS),
    .TRIPCNT_W     (TRIPCNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .kick        (kick),
    .clear       (clear),
    .timeout_cfg (timeout_cfg),
    .window_cfg  (window_cfg),
    .trip_mask   (trip_mask),
    .triggered   (triggered),
    .warning     (warning),
    .early_fault (early_fault),
    .kill        (kill),
    .remaining   (remaining),
    .trip_count  (trip_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  function automatic bit m_trig(input int c);
    return (m_mode[c] == M_TRIP) || (m_mode[c] == M_HOLD);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_clock();
    bit kill_n;
    int t_cfg;
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        m_mode[c] = M_OFF; m_cnt[c] = 0; m_tlat[c] = 0; m_wlat[c] = 0;
        m_thr[c] = 0; m_tc[c] = 0; m_ef[c] = 1'b0;
      end
      m_presc = 0; m_tick = 1'b0; m_kill = 1'b0;
      return;
    end
    kill_n = 1'b0;
    for (int c = 0; c < N_CH; c++)
      if (m_trig(c) && trip_mask[c]) kill_n = 1'b1;
    m_tick  = (m_presc == DIV - 1);
    m_presc = m_tick ? 0 : m_presc + 1;
    for (int c = 0; c < N_CH; c++) begin
      t_cfg = int'(timeout_cfg[c*CNT_W +: CNT_W]);
      if (!enable[c]) begin
        m_mode[c] = M_OFF; m_cnt[c] = 0; m_ef[c] = 1'b0;
      end else begin
        case (m_mode[c])
          M_OFF: if (t_cfg != 0) begin
            m_mode[c] = M_CNT; m_cnt[c] = 0;
            m_tlat[c] = t_cfg; m_thr[c] = (t_cfg * WARN_PCT) / 100;
            m_wlat[c] = int'(window_cfg[c*CNT_W +: CNT_W]);
          end
          M_CNT: begin
            if (kick[c]) begin
              if (WIN && m_cnt[c] < m_wlat[c]) begin
                m_mode[c] = M_TRIP; m_cnt[c] = 0; m_ef[c] = 1'b1;
                m_tc[c] = (m_tc[c] < 255) ? m_tc[c] + 1 : 255;
              end else begin
                m_cnt[c] = 0;
                m_tlat[c] = t_cfg; m_thr[c] = (t_cfg * WARN_PCT) / 100;
                m_wlat[c] = int'(window_cfg[c*CNT_W +: CNT_W]);
              end
            end else if (m_tick) begin
              if (m_cnt[c] + 1 >= m_tlat[c]) begin
                m_mode[c] = M_TRIP; m_cnt[c] = 0;
                m_tc[c] = (m_tc[c] < 255) ? m_tc[c] + 1 : 255;
              end else begin
                m_cnt[c] = m_cnt[c] + 1;
              end
            end
          end
          M_TRIP: if (clear[c]) begin m_mode[c] = M_HOLD; m_cnt[c] = 0; end
          default: if (m_tick) begin
            if (m_cnt[c] + 1 >= HOLDOFF_TICKS) begin
              m_mode[c] = M_CNT; m_cnt[c] = 0; m_ef[c] = 1'b0;
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end
        endcase
      end
    end
    m_kill = kill_n;
  endtask

  // {triggered, warning, early_fault, kill, remaining, trip_count}
  function automatic logic [54:0] exp_vec();
    logic [1:0]  tr;
    logic [1:0]  wa;
    logic [1:0]  ef;
    logic [31:0] rem;
    logic [15:0] tc;
    tr = '0; wa = '0; ef = '0; rem = '0; tc = '0;
    for (int c = 0; c < N_CH; c++) begin
      tr[c] = m_trig(c);
      wa[c] = tr[c] || (m_mode[c] == M_CNT && m_cnt[c] >= m_thr[c]);
      ef[c] = m_ef[c];
      rem[c*CNT_W +: CNT_W]    = (m_mode[c] == M_CNT) ? 16'(m_tlat[c] - m_cnt[c]) : 16'd0;
      tc[c*TRIPCNT_W +: TRIPCNT_W] = 8'(m_tc[c]);
    end
    return {tr, wa, ef, m_kill, rem, tc};
  endfunction

  function automatic logic [54:0] obs_vec();
    return {triggered, warning, early_fault, kill, remaining, trip_count};
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < (n + 2) * DIV) begin
      step();
      guard++;
      if (m_tick) seen++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = '0; trip_mask = '0; timeout_cfg = '0; window_cfg = '0;
    for (int i = 0; i < 5; i++) begin
      enable = 2'($urandom_range(3));
      kick   = 2'($urandom_range(3));
      step();
    end
    vectors++;
    if (obs_vec() !== 55'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", obs_vec());
    end
    vectors++;
    if (dut.presc !== '0) begin
      miscompares++;
      $display("FAIL reset_prescaler: got %0d, required 0", dut.presc);
    end
    enable = '0; kick = '0;
    rst_n  = 1'b1;
  endtask

  task automatic test_basic_trip();
    int ticks = 0, cyc = 0, warn_at = -1, trip_at = -1, rise_cyc = -1, kill_cyc = -1;
    timeout_cfg = {16'd7, 16'd10}; window_cfg = '0; trip_mask = 2'b01; enable = 2'b01;
    step();
    while ((trip_at < 0 || kill_cyc < 0) && cyc < 300) begin
      step(); cyc++;
      if (m_tick) ticks++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic_trip_cycle: got %h, required %h", obs_vec(), exp_vec());
      end
      if (warn_at < 0 && warning[0] === 1'b1) warn_at = ticks;
      if (trip_at < 0 && triggered[0] === 1'b1) begin trip_at = ticks; rise_cyc = cyc; end
      if (kill_cyc < 0 && kill === 1'b1) kill_cyc = cyc;
    end
    vectors++;
    if (warn_at != 8) begin miscompares++; $display("FAIL basic_warn_tick: got %0d, required 8", warn_at); end
    vectors++;
    if (trip_at != 10) begin miscompares++; $display("FAIL basic_trip_tick: got %0d, required 10", trip_at); end
    vectors++;
    if (kill_cyc - rise_cyc != 1) begin
      miscompares++; $display("FAIL basic_kill_lag: got %0d, required 1", kill_cyc - rise_cyc);
    end
    vectors++;
    if (trip_count[7:0] !== 8'd1) begin miscompares++; $display("FAIL basic_trip_count: got %0d, required 1", trip_count[7:0]); end
    vectors++;
    if (remaining[15:0] !== 16'd0) begin miscompares++; $display("FAIL basic_remaining: got %0d, required 0", remaining[15:0]); end
  endtask

  task automatic test_kicking();
    int ticks = 0, since = 0, guard = 0;
    bit kicked;
    enable = 2'b00; step();
    enable = 2'b01; step();
    while (ticks < 50 && guard < 2000) begin
      kicked = (m_presc == DIV - 1) && (since == 8);
      kick = kicked ? 2'b01 : 2'b00;
      step(); guard++;
      kick = 2'b00;
      if (m_tick) ticks++;
      if (kicked) since = 0;
      else if (m_tick) since++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL kicking_cycle: got %h, required %h", obs_vec(), exp_vec());
      end
      vectors++;
      if (triggered[0] !== 1'b0) begin miscompares++; $display("FAIL kicking_no_trip: got %b, required 0", triggered[0]); end
      if (kicked) begin
        vectors++;
        if (remaining[15:0] !== 16'd10) begin
          miscompares++; $display("FAIL kick_on_tick: remaining %0d, required 10", remaining[15:0]);
        end
      end
    end
  endtask

  task automatic test_sticky_hold();
    int guard = 0, hold_ticks = 0;
    while (triggered[0] !== 1'b1 && guard < 300) begin step(); guard++; end
    vectors++;
    if (triggered[0] !== 1'b1) begin miscompares++; $display("FAIL sticky_wait: triggered %b, required 1", triggered[0]); end
    for (int i = 0; i < 3; i++) begin
      kick = 2'b01; step(); kick = 2'b00; step();
      vectors++;
      if (obs_vec() !== exp_vec() || triggered[0] !== 1'b1 || remaining[15:0] !== 16'd0) begin
        miscompares++; $display("FAIL sticky_kick: got %h, required %h", obs_vec(), exp_vec());
      end
    end
    clear = 2'b01; step(); clear = 2'b00;
    guard = 0;
    while (triggered[0] === 1'b1 && guard < 100) begin
      step(); guard++;
      if (m_tick) hold_ticks++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL hold_cycle: got %h, required %h", obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (hold_ticks != 3) begin miscompares++; $display("FAIL holdoff_ticks: got %0d, required 3", hold_ticks); end
    vectors++;
    if (remaining[15:0] !== 16'd10) begin miscompares++; $display("FAIL rearm_remaining: got %0d, required 10", remaining[15:0]); end
    clear = 2'b01; step(); clear = 2'b00;
    vectors++;
    if (obs_vec() !== exp_vec() || triggered[0] !== 1'b0) begin
      miscompares++; $display("FAIL clear_in_run: got %h, required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_mask_independence();
    int guard = 0;
    enable = 2'b10; timeout_cfg = {16'd5, 16'd10}; trip_mask = 2'b01;
    step();
    while (triggered[1] !== 1'b1 && guard < 200) begin step(); guard++; end
    step();
    vectors++;
    if (triggered[1] !== 1'b1 || kill !== 1'b0) begin
      miscompares++; $display("FAIL masked_trip: triggered[1]=%b kill=%b, required 1 and 0", triggered[1], kill);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL masked_state: got %h, required %h", obs_vec(), exp_vec()); end
    enable = 2'b00; step();
    vectors++;
    if (triggered[1] !== 1'b0 || trip_count[15:8] !== 8'd1) begin
      miscompares++; $display("FAIL disable_keeps_count: triggered=%b count=%0d, required 0 and 1", triggered[1], trip_count[15:8]);
    end
    timeout_cfg = {16'd1, 16'd10};
    for (int i = 0; i < 260; i++) begin
      enable = 2'b10; guard = 0;
      step();
      while (triggered[1] !== 1'b1 && guard < 30) begin step(); guard++; end
      enable = 2'b00; step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL saturate_iter %0d: got %h, required %h", i, obs_vec(), exp_vec()); end
    end
    vectors++;
    if (trip_count[15:8] !== 8'hFF) begin miscompares++; $display("FAIL trip_count_saturation: got %0d, required 255", trip_count[15:8]); end
  endtask

  task automatic test_window();
    enable = 2'b00; step();
    timeout_cfg = {16'd5, 16'd10}; window_cfg = {16'd0, 16'd4}; trip_mask = 2'b01;
    enable = 2'b01; step();
    wait_ticks(2);
    kick = 2'b01; step(); kick = 2'b00;
    vectors++;
    if (triggered[0] !== WIN || early_fault[0] !== WIN) begin
      miscompares++; $display("FAIL early_kick: triggered=%b early=%b, required %b", triggered[0], early_fault[0], WIN);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL early_kick_state: got %h, required %h", obs_vec(), exp_vec()); end
    enable = 2'b00; step();
    enable = 2'b01; step();
    wait_ticks(6);
    kick = 2'b01; step(); kick = 2'b00;
    vectors++;
    if (triggered[0] !== 1'b0 || remaining[15:0] !== 16'd10) begin
      miscompares++; $display("FAIL late_kick: triggered=%b remaining=%0d, required 0 and 10", triggered[0], remaining[15:0]);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL late_kick_state: got %h, required %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    enable = 2'b11; timeout_cfg = {16'd9, 16'd12}; window_cfg = {16'd2, 16'd3}; trip_mask = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(99) < 2) enable[c] = ~enable[c];
        kick[c]  = ($urandom_range(99) < 2);
        clear[c] = ($urandom_range(99) < 3);
        if ($urandom_range(99) < 2) timeout_cfg[c*CNT_W +: CNT_W] = 16'($urandom_range(15));
        if ($urandom_range(99) < 2) window_cfg[c*CNT_W +: CNT_W]  = 16'($urandom_range(6));
      end
      if ($urandom_range(99) < 2) trip_mask = 2'($urandom_range(3));
      step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random_cycle %0d: got %h, required %h", i, obs_vec(), exp_vec());
      end
    end
    kick = '0; clear = '0;
  endtask

  initial begin
    test_reset();
    test_basic_trip();
    test_kicking();
    test_sticky_hold();
    test_mask_independence();
    test_window();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
